mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have ports: i_read input 1, i_address input 32, i_rdata output 256, i_resp output 1  (icache line-fill port, read-only).
REQ-004 SHALL have ports: d_read input 1, d_write input 1, d_address input 32, d_wdata input 256, d_rdata output 256, d_resp output 1  (dcache line port).
REQ-005 SHALL have ports: pmem_read output 1, pmem_write output 1, pmem_address output 32, pmem_wdata output 256, pmem_rdata input 256, pmem_resp input 1  (single shared physical-memory port).

Function
REQ-006 SHALL implement FSM states IDLE, SERVE_I, SERVE_D; exactly one state active.
REQ-007 IDLE: pmem_read=pmem_write=0, i_resp=d_resp=0.
REQ-008 IDLE, rising edge with exactly one requester pending (i_read, or d_read|d_write) -> go to its SERVE state and latch that requester's address, wdata and direction into internal registers.
REQ-009 IDLE, both pending on same edge -> winner per REQ-024/REQ-025; loser keeps waiting, no state change for it.
REQ-010 d_read and d_write both high SHALL be treated as a write.
REQ-011 SERVE_x: pmem_read/pmem_write, pmem_address, pmem_wdata SHALL be driven only from the latched registers, never combinationally from requester inputs; request latency = 1 cycle (request seen at edge N, pmem strobe high from N to the completion edge).
REQ-012 SERVE_I: pmem_read=1, pmem_write=0; pmem_wdata=latched value (don't-care to memory).
REQ-013 SERVE_x: x_resp = pmem_resp (combinational, same cycle); x_rdata = pmem_rdata whenever state is SERVE_x; the other requester's resp SHALL be 0.
REQ-014 SERVE_x, edge with pmem_resp=1 -> IDLE; pmem strobes drop in the following cycle; at least one IDLE cycle between any two transactions.
REQ-015 SERVE_x, pmem_resp=0 -> remain; requester deassertion mid-transaction SHALL NOT abort it; the transaction completes from latched values and the resp pulse is still issued.
REQ-016 Requesters SHALL deassert their request in the cycle after their resp; a request still high in IDLE is treated as a new request.
REQ-017 pmem_resp while in IDLE SHALL be ignored (no resp to either requester).
REQ-018 pmem_read and pmem_write SHALL never be high simultaneously.
REQ-019 i_rdata/d_rdata outside their SERVE state SHALL be 0.

Reset
REQ-020 rst_n=0 SHALL immediately (asynchronously) force state IDLE, clear latched address/wdata/direction to 0, and clear round-robin history to "icache last".
REQ-021 During reset all outputs SHALL be 0.
REQ-022 Reset mid-transaction SHALL abandon it; no resp is issued for it; after release, pending requests arbitrate afresh.
REQ-023 First edge after rst_n rises MAY grant a request.

Configuration
REQ-024 Macro MEM_ARB_RR_EN defined: on simultaneous requests in IDLE, grant the requester not granted most recently (1-bit history, updated on every grant).
REQ-025 MEM_ARB_RR_EN undefined: fixed priority, dcache always wins simultaneous requests; no history register present.

Verification
REQ-026 i_read=1, i_address=0x0000_0040, memory resp after 3 cycles with rdata=0xA5..A5 -> pmem_read high 3 cycles with address 0x40, i_resp single-cycle pulse, i_rdata=0xA5..A5, d_resp=0.
REQ-027 d_write=1, d_address=0x0000_1000, d_wdata=0x1234..; drop d_address to 0 one cycle after grant -> pmem_address stays 0x1000, pmem_write=1, pmem_read=0, d_resp on pmem_resp.
REQ-028 i_read and d_read both high same cycle, fixed priority -> SERVE_D first, then IDLE one cycle, then SERVE_I; with MEM_ARB_RR_EN after a prior dcache grant -> SERVE_I first.
REQ-029 rst_n driven low mid SERVE_D between clock edges -> pmem_write=0 and state IDLE immediately, no d_resp; after release a held i_read is granted.
REQ-030 pmem_resp pulsed in IDLE with no requests -> i_resp=d_resp=0, state stays IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: arbitrates an icache line-fill port and a dcache line port onto a
// single shared physical-memory port. One transaction is in flight at a time;
// the winning request is captured into internal registers at grant and the
// memory port is driven only from those registers until pmem_resp completes it.
//
// Build option:
//   MEM_ARB_RR_EN  defined   -> simultaneous requests alternate (1-bit history,
//                               reset to "icache granted last").
//                  undefined -> fixed priority, dcache wins simultaneous requests.
module mem_arbiter (
  input  logic         clk,
  input  logic         rst_n,
  // icache line-fill port (read only)
  input  logic         i_read,
  input  logic [31:0]  i_address,
  output logic [255:0] i_rdata,
  output logic         i_resp,
  // dcache line port
  input  logic         d_read,
  input  logic         d_write,
  input  logic [31:0]  d_address,
  input  logic [255:0] d_wdata,
  output logic [255:0] d_rdata,
  output logic         d_resp,
  // shared physical-memory port
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next_state;

  // Captured transaction: everything the memory port needs while serving.
  logic [31:0]    r_addr;
  logic [255:0]   r_wdata;
  logic           r_write;

  logic           w_i_req;
  logic           w_d_req;
  logic           w_d_wins;
  logic           w_grant_i;
  logic           w_grant_d;

  assign w_i_req = i_read;
  // A dcache request is either direction; both high is treated as a write below.
  assign w_d_req = d_read | d_write;

`ifdef MEM_ARB_RR_EN
  // High when the dcache received the most recent grant.
  logic           r_last_d;

  // On a tie, the requester that did not win last time gets the grant.
  assign w_d_wins = ~r_last_d;

  // Record which requester won each grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_d <= 1'b0;
    end else if (w_grant_i || w_grant_d) begin
      r_last_d <= w_grant_d;
    end
  end
`else
  // Fixed priority: the dcache wins every tie.
  assign w_d_wins = 1'b1;
`endif

  // Grants are only issued from IDLE, which also enforces the idle gap
  // between consecutive transactions.
  assign w_grant_d = (r_state == IDLE) & w_d_req & (~w_i_req | w_d_wins);
  assign w_grant_i = (r_state == IDLE) & w_i_req & ~w_grant_d;

  // State register.
  // NOTE: clocked state uses non-blocking (<=) so every flop samples the
  // pre-edge values of the others; blocking here would create order-dependent
  // simulation that no longer matches the synthesized flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic: grant from IDLE, return to IDLE on memory completion.
  always_comb begin
    // NOTE: default assignment first so no path leaves w_next_state unassigned,
    // which would otherwise infer a latch.
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (w_grant_d) begin
          w_next_state = SERVE_D;
        end else if (w_grant_i) begin
          w_next_state = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        if (pmem_resp) begin
          w_next_state = IDLE;
        end
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Capture the winner's address, data and direction at the grant edge so a
  // requester changing or dropping its inputs mid-transaction has no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr  <= '0;
      r_wdata <= '0;
      r_write <= 1'b0;
    end else if (w_grant_d) begin
      r_addr  <= d_address;
      r_wdata <= d_wdata;
      r_write <= d_write;
    end else if (w_grant_i) begin
      r_addr  <= i_address;
      r_wdata <= '0;
      r_write <= 1'b0;
    end
  end

  // Output decode: strobes from state plus captured direction; responses and
  // read data are steered to the requester being served, zero otherwise.
  always_comb begin
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_address = r_addr;
    pmem_wdata   = r_wdata;
    i_rdata      = '0;
    i_resp       = 1'b0;
    d_rdata      = '0;
    d_resp       = 1'b0;
    case (r_state)
      SERVE_I: begin
        pmem_read = 1'b1;
        i_rdata   = pmem_rdata;
        i_resp    = pmem_resp;
      end
      SERVE_D: begin
        pmem_read  = ~r_write;
        pmem_write = r_write;
        d_rdata    = pmem_rdata;
        d_resp     = pmem_resp;
      end
      default: ;
    endcase
  end

endmodule
